// File: rtl/rx_ltssm_pkg.sv
// Shared encodings and per-substate settings for the LTSSM RX substate engine.
package rx_ltssm_pkg;

    localparam logic [3:0] detectQuiet                  = 4'd0;
    localparam logic [3:0] detectActive                 = 4'd1;
    localparam logic [3:0] pollingActive                = 4'd2;
    localparam logic [3:0] pollingConfiguration         = 4'd3;
    localparam logic [3:0] configurationLinkWidthStart  = 4'd4;
    localparam logic [3:0] configurationLinkWidthAccept = 4'd5;
    localparam logic [3:0] configurationLanenumWait     = 4'd6;
    localparam logic [3:0] configurationLanenumAccept   = 4'd7;
    localparam logic [3:0] configurationComplete        = 4'd8;
    localparam logic [3:0] configurationIdle            = 4'd9;
    localparam logic [3:0] recoveryRcvrLock             = 4'd10;
    localparam logic [3:0] recoveryRcvrCfg              = 4'd11;
    localparam logic [3:0] recoveryIdle                 = 4'd12;
    localparam logic [3:0] l0                           = 4'd13;

    localparam logic [3:0] countMax = 4'd15;

    typedef enum logic {
        ruleAll = 1'b0,
        ruleAny = 1'b1
    } laneRule_t;

    typedef enum logic [1:0] {
        stIdle,
        stArm,
        stCount,
        stDone
    } engineState_t;

    function automatic logic [3:0] req_count(input logic [3:0] sub);
        case (sub)
            pollingActive, pollingConfiguration, configurationComplete,
            configurationIdle, recoveryRcvrLock, recoveryRcvrCfg:
                req_count = 4'd8;
            configurationLinkWidthStart, configurationLinkWidthAccept,
            configurationLanenumWait, configurationLanenumAccept, recoveryIdle:
                req_count = 4'd2;
            default:
                req_count = 4'd0;
        endcase
    endfunction

    function automatic logic [5:0] timeout_ms(input logic [3:0] sub);
        case (sub)
            detectQuiet, detectActive:                          timeout_ms = 6'd12;
            pollingConfiguration, recoveryRcvrCfg:              timeout_ms = 6'd48;
            pollingActive, configurationLinkWidthStart,
            configurationLinkWidthAccept, configurationLanenumAccept,
            recoveryRcvrLock:                                   timeout_ms = 6'd24;
            configurationLanenumWait, configurationComplete,
            configurationIdle, recoveryIdle:                    timeout_ms = 6'd2;
            default:                                            timeout_ms = 6'd1;
        endcase
    endfunction

    function automatic laneRule_t lane_rule(input logic [3:0] sub);
        lane_rule = (sub == configurationLinkWidthStart) ? ruleAny : ruleAll;
    endfunction

    function automatic logic [3:0] fail_target(input logic [3:0] sub);
        fail_target = (sub == recoveryRcvrLock) ? configurationLinkWidthStart : detectQuiet;
    endfunction

    function automatic logic [3:0] success_target(input logic [3:0] sub);
        if (sub == configurationIdle || sub == recoveryIdle) begin
            success_target = l0;
        end else if (sub <= recoveryIdle) begin
            success_target = sub + 4'd1;
        end else begin
            success_target = detectQuiet;
        end
    endfunction

endpackage

// File: rtl/rx_ltssm_substate_engine_counter.sv
// Saturating consecutive-ordered-set counter for a single lane.
module rx_lane_os_counter
    import rx_ltssm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       match,
    input  logic       mismatch,
    input  logic [3:0] req,
    output logic       reached
);

    logic [3:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            // A mismatch breaks the consecutive run even if a match arrives with it.
            if (mismatch) begin
                count <= '0;
            end else if (match && count != countMax) begin
                count <= count + 4'd1;
            end
        end
    end

    assign reached = (count >= req);

endmodule

// File: rtl/rx_ltssm_substate_engine.sv
// RX substate engine: runs one LTSSM substate request, counting per-lane ordered
// sets against an ALL/ANY rule with a millisecond-scaled timeout.
module rx_ltssm_substate_engine
    import rx_ltssm_pkg::*;
#(
    parameter int MAXLANES      = 16,
    parameter int CYCLES_PER_MS = 1000,
    parameter int TIMER_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [3:0]          substate,
    input  logic [MAXLANES-1:0] activeLanes,
    input  logic [MAXLANES-1:0] laneMatch,
    input  logic [MAXLANES-1:0] laneMismatch,
    input  logic [MAXLANES-1:0] rxElectricalIdle,
    input  logic                forceDetect,
    output logic                busy,
    output logic                done,
    output logic                success,
    output logic [3:0]          exitTo,
    output logic [MAXLANES-1:0] osCheckerClear,
    output logic                disableDescrambler,
    output logic                timeoutFlag
);

    engineState_t state;
    engineState_t nextState;

    logic [3:0]          curSub;
    logic [MAXLANES-1:0] lanes;
    logic [TIMER_W-1:0]  timer;
    logic [TIMER_W-1:0]  timerLoad;
    logic                timerLast;
    logic [3:0]          reqNow;
    logic [MAXLANES-1:0] reached;
    logic                ruleMet;
    logic                countClear;
    logic                countEnable;

    logic       evalSuccess;
    logic       evalTimeout;
    logic [3:0] evalExit;

    logic                busyD;
    logic                doneD;
    logic                successD;
    logic [3:0]          exitD;
    logic                timeoutD;
    logic [MAXLANES-1:0] clearD;
    logic                descrD;
    logic [3:0]          nextSub;

    assign reqNow      = req_count(curSub);
    assign timerLoad   = TIMER_W'(timeout_ms(curSub)) * TIMER_W'(CYCLES_PER_MS);
    assign timerLast   = (timer == TIMER_W'(1));
    assign countClear  = (state == stArm);
    assign countEnable = (state == stCount);

    for (genvar i = 0; i < MAXLANES; i++) begin : gLane
        rx_lane_os_counter uCounter (
            .clk      (clk),
            .reset    (reset),
            .clear    (countClear),
            .enable   (countEnable && lanes[i]),
            .match    (laneMatch[i]),
            .mismatch (laneMismatch[i]),
            .req      (reqNow),
            .reached  (reached[i])
        );
    end

    // Inactive lanes count as satisfied for ALL and as absent for ANY.
    assign ruleMet = (lane_rule(curSub) == ruleAny) ? |(reached & lanes)
                                                    : &(reached | ~lanes);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= stIdle;
            busy               <= 1'b0;
            done               <= 1'b0;
            success            <= 1'b0;
            exitTo             <= detectQuiet;
            timeoutFlag        <= 1'b0;
            osCheckerClear     <= '0;
            disableDescrambler <= 1'b0;
        end else begin
            state              <= nextState;
            busy               <= busyD;
            done               <= doneD;
            success            <= successD;
            exitTo             <= exitD;
            timeoutFlag        <= timeoutD;
            osCheckerClear     <= clearD;
            disableDescrambler <= descrD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curSub <= detectQuiet;
            lanes  <= '0;
        end else if (forceDetect) begin
            curSub <= detectQuiet;
        end else if (state == stIdle && start) begin
            curSub <= substate;
            lanes  <= activeLanes;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (nextState != stCount) begin
            timer <= '0;
        end else if (state == stArm) begin
            timer <= timerLoad;
        end else begin
            timer <= timer - TIMER_W'(1);
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        nextState   = state;
        evalSuccess = 1'b0;
        evalTimeout = 1'b0;
        evalExit    = detectQuiet;
        unique case (state)
            stIdle: begin
                if (start) nextState = stArm;
            end
            stArm: begin
                nextState = stCount;
            end
            stCount: begin
                if (curSub > recoveryIdle) begin
                    nextState = stDone;
                end else if (curSub == detectQuiet) begin
                    if (|(lanes & ~rxElectricalIdle)) begin
                        nextState   = stDone;
                        evalSuccess = 1'b1;
                        evalExit    = detectActive;
                    end else if (timerLast) begin
                        nextState   = stDone;
                        evalSuccess = 1'b1;
                        evalExit    = detectActive;
                        evalTimeout = 1'b1;
                    end
                end else if (reqNow == 4'd0) begin
                    nextState   = stDone;
                    evalSuccess = 1'b1;
                    evalExit    = success_target(curSub);
                end else if (lanes == '0) begin
                    nextState = stDone;
                    evalExit  = fail_target(curSub);
                end else if (ruleMet) begin
                    nextState   = stDone;
                    evalSuccess = 1'b1;
                    evalExit    = success_target(curSub);
                end else if (timerLast) begin
                    nextState   = stDone;
                    evalExit    = fail_target(curSub);
                    evalTimeout = 1'b1;
                end
            end
            stDone: begin
                nextState = stIdle;
            end
            default: begin
                nextState = stIdle;
            end
        endcase
        if (forceDetect) nextState = stArm;
    end

    always_comb begin
        nextSub = curSub;
        if (forceDetect) begin
            nextSub = detectQuiet;
        end else if (state == stIdle && start) begin
            nextSub = substate;
        end

        busyD  = (nextState != stIdle);
        doneD  = (nextState == stDone);
        descrD = busyD && (nextSub <= pollingConfiguration);

        clearD = '0;
        if (nextState == stArm) begin
            clearD = (state == stIdle && start && !forceDetect) ? activeLanes : lanes;
        end

        successD = success;
        exitD    = exitTo;
        timeoutD = timeoutFlag;
        if (nextState == stArm) begin
            successD = 1'b0;
            exitD    = detectQuiet;
            timeoutD = 1'b0;
        end else if (nextState == stDone) begin
            successD = evalSuccess;
            exitD    = evalExit;
            timeoutD = evalTimeout;
        end
    end

endmodule

// File: tb/tb_rx_ltssm_substate_engine.sv
// Randomized and directed bench for rx_ltssm_substate_engine against a table-driven model.
module tb_rx_ltssm_substate_engine;

    localparam int MAXLANES = 16;
    localparam int CPM      = 10;
    localparam int TIMER_W  = 32;
    localparam int PLANLEN  = 600;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [3:0]          substate;
    logic [MAXLANES-1:0] activeLanes;
    logic [MAXLANES-1:0] laneMatch;
    logic [MAXLANES-1:0] laneMismatch;
    logic [MAXLANES-1:0] rxElectricalIdle;
    logic                forceDetect;
    logic                busy;
    logic                done;
    logic                success;
    logic [3:0]          exitTo;
    logic [MAXLANES-1:0] osCheckerClear;
    logic                disableDescrambler;
    logic                timeoutFlag;

    int vectors     = 0;
    int miscompares = 0;

    // Substate table: required count, timeout ms, ANY rule, fail target, success target.
    int reqTab[16]  = '{0, 0, 8, 8, 2, 2, 2, 2, 8, 8, 8, 8, 2, 0, 0, 0};
    int msTab[16]   = '{12, 12, 24, 48, 24, 24, 2, 24, 2, 2, 24, 48, 2, 1, 1, 1};
    int anyTab[16]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int failTab[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0};
    int passTab[16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 13, 11, 12, 13, 0, 0, 0};

    logic [MAXLANES-1:0] matchPlan[PLANLEN];
    logic [MAXLANES-1:0] mismatchPlan[PLANLEN];

    always #5 clk = ~clk;

    rx_ltssm_substate_engine #(
        .MAXLANES      (MAXLANES),
        .CYCLES_PER_MS (CPM),
        .TIMER_W       (TIMER_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .substate           (substate),
        .activeLanes        (activeLanes),
        .laneMatch          (laneMatch),
        .laneMismatch       (laneMismatch),
        .rxElectricalIdle   (rxElectricalIdle),
        .forceDetect        (forceDetect),
        .busy               (busy),
        .done               (done),
        .success            (success),
        .exitTo             (exitTo),
        .osCheckerClear     (osCheckerClear),
        .disableDescrambler (disableDescrambler),
        .timeoutFlag        (timeoutFlag)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_busy"}, 32'(busy), 0);
        checkVal({tag, "_done"}, 32'(done), 0);
        checkVal({tag, "_success"}, 32'(success), 0);
        checkVal({tag, "_exitTo"}, 32'(exitTo), 0);
        checkVal({tag, "_timeout"}, 32'(timeoutFlag), 0);
        checkVal({tag, "_osClear"}, 32'(osCheckerClear), 0);
        checkVal({tag, "_descr"}, 32'(disableDescrambler), 0);
    endtask

    task automatic checkArm(input logic [15:0] lanes, input logic [3:0] sub);
        checkVal("arm_busy", 32'(busy), 1);
        checkVal("arm_done", 32'(done), 0);
        checkVal("arm_osClear", 32'(osCheckerClear), 32'(lanes));
        checkVal("arm_success", 32'(success), 0);
        checkVal("arm_exitTo", 32'(exitTo), 0);
        checkVal("arm_timeout", 32'(timeoutFlag), 0);
        checkVal("arm_descr", 32'(disableDescrambler), 32'(sub <= 4'd3));
    endtask

    task automatic clearPlan();
        for (int i = 0; i < PLANLEN; i++) begin
            matchPlan[i]    = '0;
            mismatchPlan[i] = '0;
        end
    endtask

    task automatic randomPlan();
        int r;
        for (int i = 0; i < PLANLEN; i++) begin
            for (int l = 0; l < MAXLANES; l++) begin
                r = int'($urandom_range(99));
                matchPlan[i][l]    = (r < 80) || (r >= 98);
                mismatchPlan[i][l] = (r >= 96);
            end
        end
    endtask

    // Runs one request; forceAt/busyStartAt/resetAt give the COUNT cycle (1-based)
    // at which to inject that event, 0 for never.
    task automatic runReq(input logic [3:0] sub, input logic [15:0] lanes,
                          input logic [15:0] idleVec, input int forceAt,
                          input int busyStartAt, input int resetAt);
        int         cnt[16];
        int         n;
        int         nMet;
        int         nAct;
        logic [3:0] cur;
        bit         decided;
        bit         forced;
        bit         expS;
        bit         expT;
        int         expE;
        bit         met;

        cur    = sub;
        forced = 1'b0;
        expS   = 1'b0;
        expT   = 1'b0;
        expE   = 0;

        @(negedge clk);
        start            = 1'b1;
        substate         = sub;
        activeLanes      = lanes;
        laneMatch        = '0;
        laneMismatch     = '0;
        rxElectricalIdle = idleVec;
        forceDetect      = 1'b0;

        @(negedge clk);
        start        = 1'b0;
        substate     = 4'($urandom);
        activeLanes  = 16'($urandom);
        checkArm(lanes, cur);
        laneMatch    = 16'($urandom);
        laneMismatch = 16'($urandom);

        foreach (cnt[i]) cnt[i] = 0;
        n       = 0;
        decided = 1'b0;
        while (!decided) begin
            @(negedge clk);
            n++;
            laneMatch    = '0;
            laneMismatch = '0;
            start        = 1'b0;
            forceDetect  = 1'b0;
            checkVal("count_busy", 32'(busy), 1);
            checkVal("count_done", 32'(done), 0);
            checkVal("count_osClear", 32'(osCheckerClear), 0);
            checkVal("count_descr", 32'(disableDescrambler), 32'(cur <= 4'd3));

            if (n == resetAt) begin
                reset = 1'b1;
                #1;
                checkAllZero("midreset");
                @(negedge clk);
                reset = 1'b0;
                checkVal("postreset_busy", 32'(busy), 0);
                return;
            end

            if (n == forceAt && !forced) begin
                forced      = 1'b1;
                forceDetect = 1'b1;
                cur         = 4'd0;
                laneMatch   = 16'($urandom);
                @(negedge clk);
                forceDetect = 1'b0;
                checkArm(lanes, cur);
                laneMatch    = 16'($urandom);
                laneMismatch = 16'($urandom);
                foreach (cnt[i]) cnt[i] = 0;
                n = 0;
                continue;
            end

            if (n == busyStartAt) begin
                start       = 1'b1;
                substate    = 4'($urandom);
                activeLanes = 16'($urandom);
            end

            if (cur > 4'd12) begin
                decided = 1'b1; expS = 1'b0; expE = 0; expT = 1'b0;
            end else if (cur == 4'd0) begin
                if ((lanes & ~idleVec) != 0) begin
                    decided = 1'b1; expS = 1'b1; expE = 1; expT = 1'b0;
                end else if (n == msTab[0] * CPM) begin
                    decided = 1'b1; expS = 1'b1; expE = 1; expT = 1'b1;
                end
            end else if (reqTab[cur] == 0) begin
                decided = 1'b1; expS = 1'b1; expE = passTab[cur]; expT = 1'b0;
            end else if (lanes == 0) begin
                decided = 1'b1; expS = 1'b0; expE = failTab[cur]; expT = 1'b0;
            end else begin
                nMet = 0;
                nAct = 0;
                for (int i = 0; i < MAXLANES; i++) begin
                    if (lanes[i]) begin
                        nAct++;
                        if (cnt[i] >= reqTab[cur]) nMet++;
                    end
                end
                met = (anyTab[cur] != 0) ? (nMet > 0) : (nMet == nAct);
                if (met) begin
                    decided = 1'b1; expS = 1'b1; expE = passTab[cur]; expT = 1'b0;
                end else if (n == msTab[cur] * CPM) begin
                    decided = 1'b1; expS = 1'b0; expE = failTab[cur]; expT = 1'b1;
                end
            end

            if (decided) begin
                laneMatch    = 16'($urandom);
                laneMismatch = 16'($urandom);
            end else begin
                laneMatch    = matchPlan[n-1];
                laneMismatch = mismatchPlan[n-1];
                for (int i = 0; i < MAXLANES; i++) begin
                    if (lanes[i]) begin
                        if (mismatchPlan[n-1][i]) cnt[i] = 0;
                        else if (matchPlan[n-1][i] && cnt[i] < 15) cnt[i]++;
                    end
                end
            end
        end

        @(negedge clk);
        start        = 1'b0;
        laneMatch    = '0;
        laneMismatch = '0;
        checkVal("done_pulse", 32'(done), 1);
        checkVal("done_busy", 32'(busy), 1);
        checkVal("done_success", 32'(success), 32'(expS));
        checkVal("done_exitTo", 32'(exitTo), 32'(expE));
        checkVal("done_timeout", 32'(timeoutFlag), 32'(expT));
        checkVal("done_descr", 32'(disableDescrambler), 32'(cur <= 4'd3));
        checkVal("done_osClear", 32'(osCheckerClear), 0);

        @(negedge clk);
        checkVal("idle_done", 32'(done), 0);
        checkVal("idle_busy", 32'(busy), 0);
        checkVal("idle_success", 32'(success), 32'(expS));
        checkVal("idle_exitTo", 32'(exitTo), 32'(expE));
        checkVal("idle_timeout", 32'(timeoutFlag), 32'(expT));
        checkVal("idle_descr", 32'(disableDescrambler), 0);
    endtask

    initial begin
        logic [3:0]  rSub;
        logic [15:0] rLanes;
        logic [15:0] rIdle;
        int          rForce;

        reset            = 1'b1;
        start            = 1'b0;
        forceDetect      = 1'b0;
        substate         = '0;
        activeLanes      = '0;
        laneMatch        = '0;
        laneMismatch     = '0;
        rxElectricalIdle = '1;
        repeat (3) @(negedge clk);
        checkAllZero("por");
        reset = 1'b0;

        // pollingActive, all four lanes see 8 matches; upper inactive lanes add noise
        clearPlan();
        for (int i = 0; i < 8; i++) matchPlan[i] = 16'hF00F;
        runReq(4'd2, 16'h000F, 16'hFFFF, 0, 0, 0);

        // configurationLinkWidthStart, ANY rule satisfied by lane 5 alone
        clearPlan();
        matchPlan[0] = 16'h0020;
        matchPlan[2] = 16'h0020;
        runReq(4'd4, 16'h00FF, 16'hFFFF, 0, 0, 0);

        // pollingConfiguration: lane 2 breaks after 7 matches, then silence to 480-cycle timeout
        clearPlan();
        for (int i = 0; i < 7; i++) matchPlan[i] = 16'h000F;
        matchPlan[7]    = 16'h000F;
        mismatchPlan[7] = 16'h0004;
        runReq(4'd3, 16'h000F, 16'hFFFF, 0, 0, 0);

        // recoveryRcvrLock timeout falls back to configurationLinkWidthStart
        clearPlan();
        runReq(4'd10, 16'h0003, 16'hFFFF, 0, 0, 0);

        // configurationIdle success goes to L0
        clearPlan();
        for (int i = 0; i < 8; i++) matchPlan[i] = 16'h0003;
        runReq(4'd9, 16'h0003, 16'hFFFF, 0, 0, 0);

        // no active lanes with a nonzero requirement fails at once
        clearPlan();
        runReq(4'd2, 16'h0000, 16'hFFFF, 0, 0, 0);

        // forceDetect mid-COUNT of configurationLanenumAccept, lane 1 leaves electrical idle
        clearPlan();
        runReq(4'd7, 16'h0003, 16'hFFFD, 3, 0, 0);

        // detectActive completes immediately; undefined code fails immediately
        runReq(4'd1, 16'h00F0, 16'hFFFF, 0, 0, 0);
        runReq(4'd14, 16'h000F, 16'hFFFF, 0, 0, 0);

        // detectQuiet: idle drop on an inactive lane is ignored, so it times out as success
        runReq(4'd0, 16'h0003, 16'hFFFB, 0, 0, 0);

        // start while busy is ignored
        clearPlan();
        matchPlan[0] = 16'h0001;
        matchPlan[1] = 16'h0001;
        runReq(4'd6, 16'h0001, 16'hFFFF, 0, 2, 0);

        // reset mid-COUNT, then a fresh request runs normally
        clearPlan();
        runReq(4'd3, 16'h000F, 16'hFFFF, 0, 0, 5);
        matchPlan[0] = 16'h0003;
        matchPlan[1] = 16'h0003;
        runReq(4'd5, 16'h0003, 16'hFFFF, 0, 0, 0);

        for (int r = 0; r < 24; r++) begin
            randomPlan();
            rSub   = 4'($urandom_range(15));
            rLanes = ($urandom_range(7) == 0) ? 16'h0000 : 16'($urandom & $urandom);
            rIdle  = ($urandom_range(2) == 0) ? ~(16'h0001 << $urandom_range(15)) : 16'hFFFF;
            rForce = ($urandom_range(4) == 0) ? int'($urandom_range(1, 20)) : 0;
            runReq(rSub, rLanes, rIdle, rForce, int'($urandom_range(0, 6)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_ltssm_substate_engine.md
# rx_ltssm_substate_engine

Parametrised RX-side substate engine for the LTSSM. The main LTSSM issues one substate request at a time. The engine then:
- counts consecutive matching ordered sets per lane, using an ALL-lanes or ANY-lane rule chosen per substate;
- runs its own millisecond-scaled timeout;
- reports success or failure, plus the next substate, back to the main LTSSM.

It supersedes the fixed-table 16-lane RX sequencer and adds Recovery substates, per-lane consecutive counting and a clean request/done handshake.

## Interface
- MAXLANES, 16, number of lane slots (1..32)
- CYCLES_PER_MS, 1000, clk cycles per millisecond of protocol timeout
- TIMER_W, 32, timer width; must hold 48*CYCLES_PER_MS
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request strobe; samples substate
- substate  in  4  requested substate, package encoding
- activeLanes  in  MAXLANES  mask of lanes that must participate, sampled with start
- laneMatch  in  MAXLANES  per-lane pulse: expected OS received this cycle
- laneMismatch  in  MAXLANES  per-lane pulse: non-matching OS received
- rxElectricalIdle  in  MAXLANES  per-lane electrical-idle status
- forceDetect  in  1  abort and run Detect.Quiet
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- success  out  1  result of last request, held until next start
- exitTo  out  4  next substate, held until next start
- osCheckerClear  out  MAXLANES  clear pulse to the OS checkers of active lanes
- disableDescrambler  out  1  high while a Detect or Polling substate is being processed
- timeoutFlag  out  1  last request ended by timer expiry

## Operation
- FSM states are IDLE, ARM, COUNT and DONE.
- IDLE:
  - start → ARM; latch substate and activeLanes; busy=1.
  - start while busy is ignored.
- ARM, one cycle:
  - clear lane counters;
  - osCheckerClear = activeLanes;
  - load timer = timeout_ms*CYCLES_PER_MS.
- COUNT:
  - timer decrements each cycle.
  - Success is evaluated before timeout in the same cycle → DONE.
- DONE, one cycle: done=1, then IDLE with busy=0.
- Lane counter:
  - 4-bit, saturates at 15.
  - laneMatch increments; laneMismatch clears it; if both are high, clear wins.
  - Inactive lanes are ignored.
- Rule ALL: every active lane count ≥ req. Rule ANY: at least one active lane ≥ req.
- If activeLanes==0 and req>0: fail on the first COUNT cycle, timeoutFlag=0.
- Per-substate settings are substate=code: req/timeout ms/rule/fail target. On success, exitTo=code+1 unless stated otherwise.
  - detectQuiet=0: success on any active lane rxElectricalIdle=0, or on timeout (timeout counts as success); 12 ms.
  - detectActive=1: req 0, immediate success.
  - pollingActive=2: 8/24/ALL/detectQuiet.
  - pollingConfiguration=3: 8/48/ALL/detectQuiet.
  - configurationLinkWidthStart=4: 2/24/ANY/detectQuiet.
  - configurationLinkWidthAccept=5: 2/24/ALL/detectQuiet.
  - configurationLanenumWait=6: 2/2/ALL/detectQuiet.
  - configurationLanenumAccept=7: 2/24/ALL/detectQuiet.
  - configurationComplete=8: 8/2/ALL/detectQuiet.
  - configurationIdle=9: 8/2/ALL/detectQuiet; on success exitTo=L0 (13).
  - recoveryRcvrLock=10: 8/24/ALL/configurationLinkWidthStart.
  - recoveryRcvrCfg=11: 8/48/ALL/detectQuiet.
  - recoveryIdle=12: 2/2/ALL/detectQuiet; on success exitTo=L0.
- Failure: success=0, exitTo=fail target, timeoutFlag=1 if the timer expired.
- forceDetect:
  - Has priority in any state, and over a simultaneous start.
  - Next state is ARM with substate detectQuiet and activeLanes held.
  - On completion exitTo=detectActive.
- Undefined substate codes 13..15 are accepted and complete as failure, exitTo=detectQuiet, on the first COUNT cycle.

## Timing
- Reset value of every output is 0, including exitTo=detectQuiet.
- A reset mid-operation returns the FSM to IDLE and clears counters and timer.
- All outputs are registered.
- start sampled at edge k: ARM after k, COUNT after k+1; the earliest done is high in the cycle after edge k+2, i.e. 3 cycles.
- laneMatch is counted only in COUNT cycles. Pulses during ARM are discarded.
- success, exitTo and timeoutFlag update in the same cycle as done.
- osCheckerClear is high only during the ARM cycle.
- A timeout of T ms expires after exactly T*CYCLES_PER_MS COUNT cycles.
- The timer is idle with value 0 outside COUNT.

## Structure
- Package rx_ltssm_pkg holds:
  - substate localparams 0..13 (L0=13);
  - rule encoding ALL/ANY;
  - functions req_count(), timeout_ms(), lane_rule() and fail_target() keyed by substate.
- Sub-module rx_lane_os_counter: one saturating per-lane counter with match/mismatch/clear and a ≥req compare output. Instantiate it MAXLANES times via generate.

## Test plan
- Set CYCLES_PER_MS=10 for all scenarios.
- pollingActive, activeLanes=0x000F, 8 laneMatch pulses on lanes 0-3 → done with success=1, exitTo=3, timeoutFlag=0.
- configurationLinkWidthStart, activeLanes=0x00FF, only lane 5 gets 2 matches → success=1 (ANY rule), exitTo=5.
- pollingConfiguration with lane 2 mismatch after 7 matches, then no traffic → done after exactly 480 COUNT cycles with success=0, exitTo=0, timeoutFlag=1.
- recoveryRcvrLock timeout → exitTo=4; configurationIdle success → exitTo=13; activeLanes=0 with req 8 → fail on the first COUNT cycle.
- forceDetect asserted mid-COUNT of state 7, lane 1 rxElectricalIdle=0 → ARM with detectQuiet, then success=1, exitTo=1.
- start during busy → ignored. reset asserted mid-COUNT → all outputs 0, busy=0 immediately; a new start afterwards runs normally.
